// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter merging per-requester TCP TX buses onto one engine bus.
// Grants are handed out via rts/cts and policed by a per-grant watchdog.
package tcp_tx_pkg;
    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
        logic [15:0] dst_port;
        logic [15:0] src_port;
        logic [31:0] dst_ip;
        logic [7:0]  sockid;
    } tcp_tx_bus_t;
endpackage

module tcp_tx_arbiter
    import tcp_tx_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = 2048
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] tcp_rts,
    output logic [NUM_PORTS-1:0] tcp_cts,
    input  tcp_tx_bus_t          req_bus [NUM_PORTS],
    output tcp_tx_bus_t          tcp_tx_bus,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_evt
);

    typedef enum logic [1:0] {IDLE, WAIT_START, ACTIVE} state_t;

    state_t      state;
    logic [2:0]  last_grant;
    logic [15:0] wd;
    logic        armed;
    logic        found;
    logic [2:0]  winner;
    logic        expired;
    tcp_tx_bus_t sel;
    tcp_tx_bus_t fwd;

    always_comb begin
        sel = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (int'(grant_id) == j) sel = req_bus[j];
        end
    end

    // Payload/address copy with every strobe cleared; strobes are set per state.
    always_comb begin
        fwd            = sel;
        fwd.start      = 1'b0;
        fwd.data_valid = 1'b0;
        fwd.commit     = 1'b0;
        fwd.drop       = 1'b0;
    end

    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!found && tcp_rts[j] &&
                    j == (int'(last_grant) + i) % NUM_PORTS) begin
                    found  = 1'b1;
                    winner = 3'(j);
                end
            end
        end
    end

    assign expired = (wd == 16'(TIMEOUT - 1));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tcp_cts     <= '0;
            tcp_tx_bus  <= '0;
            grant_id    <= '0;
            last_grant  <= 3'(NUM_PORTS - 1);
            wd          <= '0;
            timeout_evt <= 1'b0;
            armed       <= 1'b0;
        end else begin
            armed                 <= 1'b1;
            tcp_cts               <= '0;
            timeout_evt           <= 1'b0;
            tcp_tx_bus.start      <= 1'b0;
            tcp_tx_bus.data_valid <= 1'b0;
            tcp_tx_bus.commit     <= 1'b0;
            tcp_tx_bus.drop       <= 1'b0;
            unique case (state)
                IDLE: begin
                    // armed delays the first grant to the second edge after reset
                    if (armed && found) begin
                        tcp_cts    <= NUM_PORTS'(1) << winner;
                        grant_id   <= winner;
                        last_grant <= winner;
                        wd         <= '0;
                        state      <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (expired) begin
                        timeout_evt <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tcp_tx_bus            <= fwd;
                        tcp_tx_bus.start      <= sel.start;
                        tcp_tx_bus.data_valid <= sel.data_valid;
                        wd                    <= wd + 16'd1;
                        if (sel.start) state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (sel.commit || sel.drop) begin
                        tcp_tx_bus            <= fwd;
                        tcp_tx_bus.start      <= sel.start;
                        tcp_tx_bus.data_valid <= sel.data_valid;
                        tcp_tx_bus.commit     <= sel.commit & ~sel.drop;
                        tcp_tx_bus.drop       <= sel.drop;
                        state                 <= IDLE;
                    end else if (expired) begin
                        tcp_tx_bus.drop <= 1'b1;
                        timeout_evt     <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        tcp_tx_bus            <= fwd;
                        tcp_tx_bus.start      <= sel.start;
                        tcp_tx_bus.data_valid <= sel.data_valid;
                        wd                    <= wd + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
